// File: rtl/spi_flash_responder.sv
// SPI-flash slave (mode 0) answering READ, FAST_READ and RDID from an external byte store.
// All SPI inputs are oversampled in the clk domain; sck edges are detected on the synchronised copy.
module spi_flash_responder #(
    parameter int          ADDR_BYTES  = 3,
    parameter int          MEM_AW      = 20,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4014,
    parameter int          DUMMY_BITS  = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              cs_n_i,
    input  logic              sck_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic              mem_rd_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic [7:0]        cmd_o,
    output logic              cmd_valid_o,
    output logic              err_o,
    output logic              busy_o
);
    localparam int          ADDR_BITS  = 8 * ADDR_BYTES;
    localparam logic [5:0]  ADDR_LAST  = 6'(ADDR_BITS - 1);
    localparam logic [5:0]  DUMMY_LAST = 6'(DUMMY_BITS - 1);
    localparam logic [31:0] ADDR_MASK  = 32'((64'd1 << ADDR_BITS) - 64'd1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_IGNORE} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q, vld_sync_q;
    logic       sck_prev_q, armed_q;
    logic       cs_s, mosi_s, sck_rise, sck_fall;
    logic [5:0] cnt_q;
    logic [30:0] sr_in_q;
    logic [7:0] cmd_q, hold_q, sr_out_q, opcode, out_byte, id_byte;
    logic       cmd_valid_q, err_q, mem_rd_q, rd_dly_q, miso_q, oe_q;
    logic [1:0] id_idx_q;
    logic [MEM_AW-1:0] mem_addr_q, addr_rx;
    logic       stream, cmd_fire, err_fire, load_addr, start_rd, next_rd;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            vld_sync_q  <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    assign opcode   = {sr_in_q[6:0], mosi_s};
    assign addr_rx  = MEM_AW'({sr_in_q, mosi_s} & ADDR_MASK);

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // armed_q stays low until cs_n has been seen high, so a burst caught at reset release is skipped
            S_IDLE:  if (armed_q) state_d = S_CMD;
            S_CMD:   if (sck_rise && cnt_q == 6'd7) begin
                         case (opcode)
                             8'h03, 8'h0B: state_d = S_ADDR;
                             8'h9F:        state_d = S_ID;
                             default:      state_d = S_IGNORE;
                         endcase
                     end
            S_ADDR:  if (sck_rise && cnt_q == ADDR_LAST)
                         state_d = (cmd_q == 8'h0B && DUMMY_BITS != 0) ? S_DUMMY : S_DATA;
            S_DUMMY: if (sck_rise && cnt_q == DUMMY_LAST) state_d = S_DATA;
            default: ;
        endcase
        if (cs_s) state_d = S_IDLE;
    end

    always_comb begin
        stream    = (state_q == S_DATA) || (state_q == S_ID);
        cmd_fire  = (state_q == S_CMD) && (state_d != S_CMD) && (state_d != S_IDLE);
        err_fire  = cmd_fire && (state_d == S_IGNORE);
        load_addr = (state_q == S_ADDR) && (state_d != S_ADDR) && (state_d != S_IDLE);
        start_rd  = ((state_q == S_ADDR) || (state_q == S_DUMMY)) && (state_d == S_DATA);
        next_rd   = (state_q == S_DATA) && (state_d == S_DATA) && sck_rise && (cnt_q[2:0] == 3'd7);
        case (id_idx_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
        out_byte  = (state_q == S_ID) ? id_byte : hold_q;
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            sr_in_q     <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            rd_dly_q    <= 1'b0;
            hold_q      <= '0;
            mem_addr_q  <= '0;
            sr_out_q    <= '1;
            miso_q      <= 1'b1;
            oe_q        <= 1'b0;
            id_idx_q    <= '0;
        end else begin
            armed_q     <= armed_q | (vld_sync_q[SYNC_STAGES-1] & cs_s);
            if (state_d != state_q || state_q == S_IDLE) cnt_q <= '0;
            else if (sck_rise)                           cnt_q <= cnt_q + 6'd1;
            if (sck_rise) sr_in_q <= {sr_in_q[29:0], mosi_s};
            if (cmd_fire) cmd_q <= opcode;
            cmd_valid_q <= cmd_fire;
            err_q       <= err_fire;
            mem_rd_q    <= start_rd | next_rd;
            rd_dly_q    <= mem_rd_q;
            if (rd_dly_q) hold_q <= mem_data_i;
            if (load_addr)     mem_addr_q <= addr_rx;
            else if (mem_rd_q) mem_addr_q <= mem_addr_q + 1'b1;
            if (state_d == S_IDLE) begin
                oe_q     <= 1'b0;
                miso_q   <= 1'b1;
                sr_out_q <= '1;
                id_idx_q <= '0;
            end else if (stream && sck_fall) begin
                oe_q <= 1'b1;
                // first fall of each byte presents bit 7 of the freshly selected byte
                if (cnt_q[2:0] == 3'd0) begin
                    miso_q   <= out_byte[7];
                    sr_out_q <= {out_byte[6:0], 1'b1};
                    if (state_q == S_ID) id_idx_q <= (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                end else begin
                    miso_q   <= sr_out_q[7];
                    sr_out_q <= {sr_out_q[6:0], 1'b1};
                end
            end
        end
    end

    assign miso_o      = miso_q;
    assign miso_oe_o   = oe_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = mem_addr_q;
    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign err_o       = err_q;
    assign busy_o      = ~cs_s;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master tasks plus a byte store returning addr[7:0].
module tb_spi_flash_responder;
    logic        clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        miso, oe, mem_rd, cmd_valid, err, busy;
    logic [19:0] mem_addr;
    logic [7:0]  cmd;

    int errors = 0, checks = 0;
    logic [19:0] addr_log[$];
    int cv_cnt = 0, err_cnt = 0, oe_cnt = 0;
    logic [7:0] cv_last = 8'h00;

    spi_flash_responder dut (
        .clk(clk), .rst_i(rst_n), .cs_n_i(cs_n), .sck_i(sck), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(oe), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
        .mem_data_i(mem_data), .cmd_o(cmd), .cmd_valid_o(cmd_valid), .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= mem_addr[7:0];
            addr_log.push_back(mem_addr);
        end
        if (cmd_valid) begin
            cv_cnt  = cv_cnt + 1;
            cv_last = cmd;
        end
        if (err) err_cnt = err_cnt + 1;
        if (oe)  oe_cnt  = oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #50; sck = 1'b1; rx[i] = miso;
            #50; sck = 1'b0;
        end
    endtask

    task automatic bits(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = 1'b0;
            #50; sck = 1'b1;
            #50; sck = 1'b0;
        end
    endtask

    task automatic cs_lo();
        cs_n = 1'b0; #100;
    endtask

    task automatic cs_hi();
        #50; cs_n = 1'b1; #100;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] rx;
        xfer(op, rx); xfer(a[23:16], rx); xfer(a[15:8], rx); xfer(a[7:0], rx);
    endtask

    initial begin
        logic [7:0] rx;
        int base_a, base_cv, base_err, base_oe;
        logic [7:0] exp_id [3];
        exp_id[0] = 8'hEF; exp_id[1] = 8'h40; exp_id[2] = 8'h14;

        #40;
        check("rst_ctl", {26'd0, miso, oe, mem_rd, cmd_valid, err, busy}, 32'b100000);
        check("rst_addr_cmd", {4'd0, mem_addr, cmd}, 32'd0);
        rst_n = 1'b1; #100;

        // T1 READ at 0x000010
        base_a = addr_log.size(); base_cv = cv_cnt;
        cs_lo(); send_cmd(8'h03, 24'h000010);
        for (int k = 0; k < 4; k++) begin
            xfer(8'h00, rx);
            check($sformatf("t1_data%0d", k), rx, 32'h10 + k);
        end
        check("t1_cv_pulses", cv_cnt - base_cv, 1);
        check("t1_cmd", cv_last, 8'h03);
        for (int k = 0; k < 4; k++) check($sformatf("t1_addr%0d", k), addr_log[base_a + k], 32'h10 + k);
        cs_hi();

        // T2 FAST_READ across the top of the address space
        base_a = addr_log.size();
        cs_lo(); send_cmd(8'h0B, 24'h0FFFFE);
        base_oe = oe_cnt;
        xfer(8'h00, rx);
        check("t2_oe_dummy", oe_cnt - base_oe, 0);
        xfer(8'h00, rx); check("t2_data0", rx, 8'hFE);
        xfer(8'h00, rx); check("t2_data1", rx, 8'hFF);
        xfer(8'h00, rx); check("t2_data2", rx, 8'h00);
        check("t2_addr0", addr_log[base_a],     20'hFFFFE);
        check("t2_addr1", addr_log[base_a + 1], 20'hFFFFF);
        check("t2_addr2", addr_log[base_a + 2], 20'h00000);
        cs_hi();

        // T3 RDID repeats the 3-byte ID
        cs_lo(); xfer(8'h9F, rx);
        for (int k = 0; k < 6; k++) begin
            xfer(8'h00, rx);
            check($sformatf("t3_id%0d", k), rx, exp_id[k % 3]);
        end
        check("t3_cmd", cv_last, 8'h9F);
        cs_hi();

        // T4 unsupported opcode, then a normal READ
        base_err = err_cnt; base_oe = oe_cnt; base_cv = cv_cnt;
        cs_lo(); xfer(8'h05, rx); xfer(8'h00, rx); xfer(8'h00, rx);
        check("t4_err_pulses", err_cnt - base_err, 1);
        check("t4_oe_low", oe_cnt - base_oe, 0);
        check("t4_cv_pulses", cv_cnt - base_cv, 1);
        check("t4_cmd", cv_last, 8'h05);
        cs_hi();
        cs_lo(); send_cmd(8'h03, 24'h000040);
        xfer(8'h00, rx); check("t4_read0", rx, 8'h40);
        xfer(8'h00, rx); check("t4_read1", rx, 8'h41);
        cs_hi();

        // T5 abort mid-byte
        base_a = addr_log.size();
        cs_lo(); send_cmd(8'h03, 24'h000030);
        bits(4);
        #20; cs_n = 1'b1;
        #30;
        check("t5_abort_oe_miso", {oe, miso}, 2'b01);
        check("t5_abort_busy", busy, 1'b0);
        #100;
        check("t5_strobes", addr_log.size() - base_a, 1);
        cs_lo(); send_cmd(8'h03, 24'h000020);
        xfer(8'h00, rx); check("t5_read", rx, 8'h20);
        cs_hi();

        // T6 reset mid-DATA; the interrupted burst must be ignored
        cs_lo(); send_cmd(8'h03, 24'h000050);
        xfer(8'h00, rx); check("t6_read", rx, 8'h50);
        bits(3);
        #2; rst_n = 1'b0; #1;
        check("t6_rst_ctl", {26'd0, miso, oe, mem_rd, cmd_valid, err, busy}, 32'b100000);
        check("t6_rst_addr_cmd", {4'd0, mem_addr, cmd}, 32'd0);
        #47; rst_n = 1'b1; #100;
        check("t6_busy_held", {oe, busy}, 2'b01);
        base_cv = cv_cnt; base_oe = oe_cnt;
        xfer(8'h9F, rx); xfer(8'h00, rx);
        check("t6_ignored_cv", cv_cnt - base_cv, 0);
        check("t6_ignored_oe", oe_cnt - base_oe, 0);
        cs_hi();
        cs_lo(); xfer(8'h9F, rx);
        for (int k = 0; k < 3; k++) begin
            xfer(8'h00, rx);
            check($sformatf("t6_id%0d", k), rx, exp_id[k]);
        end
        cs_hi();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
